// File: rtl/vsim_pkg.sv
// Shared constants, types and host hook for the vsim beat channel.
// An in-process queue stands in for the host transport.
package vsim_pkg;

  localparam int VSIM_BEAT_VALID_BIT = 33;
  localparam int VSIM_BEAT_LAST_BIT  = 32;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef enum logic {
    POLL_READY,
    POLL_BACKOFF
  } poll_state_t;

  longint      host_q[$];
  int unsigned host_calls;

  // Same word layout as the C transport; an empty queue reads as "no beat".
  function automatic longint dpi_msgReceive_beat();
    host_calls = host_calls + 1;
    if (host_q.size() == 0) return 64'sd0;
    return host_q.pop_front();
  endfunction

endpackage

// File: rtl/vsim_beat_fifo.sv
// Small power-of-two beat FIFO holding {last, data}; head outputs read as zero when empty.
module vsim_beat_fifo
  import vsim_pkg::*;
#(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [width-1:0]           push_data,
  input  logic                       push_last,
  input  logic                       pop,
  output logic [width-1:0]           head_data,
  output logic                       head_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [width-1:0] mem_data [DEPTH];
  logic             mem_last [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= push_data;
      mem_last[wr_ptr] <= push_last;
    end
  end

  assign head_data = empty ? '0   : mem_data[rd_ptr];
  assign head_last = empty ? 1'b0 : mem_last[rd_ptr];

endmodule

// File: rtl/vsim_receive.sv
// Receive side of the host<->RTL beat channel: polls the host for beats and offers them on ENA/RDY.
// Define VSIM_RECEIVE_STATS_EN to add saturating traffic counters reported at end of simulation.
module vsim_receive
  import vsim_pkg::*;
#(
  parameter int width         = 32,
  parameter int DEPTH         = 4,
  parameter int POLL_INTERVAL = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             beat__ENA,
  input  logic             beat__RDY,
  output logic [width-1:0] beat_v,
  output logic             beat_last,
  output logic             inMessage
);

  localparam int             CW     = $clog2(DEPTH + 1);
  localparam int             PCW    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PCW-1:0] RELOAD = PCW'(POLL_INTERVAL - 1);

  poll_state_t      state;
  poll_state_t      state_nxt;
  logic [PCW-1:0]   poll_cnt;
  logic [PCW-1:0]   poll_cnt_nxt;
  logic             poll_now;
  logic             fetch_made;
  logic [63:0]      fetch_word;
  logic             fetch_valid;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [width-1:0] head_data;
  logic             head_last;
  logic             unused_bits;

  assign poll_now    = (state == POLL_READY) && !full;
  assign fetch_valid = fetch_word[VSIM_BEAT_VALID_BIT];
  assign push        = fetch_made && fetch_valid;
  assign pop         = beat__ENA && beat__RDY;
  assign unused_bits = ^{fetch_word, count};

  // The host is queried half a cycle ahead so its answer is ready to push on the
  // rising edge the poll belongs to; the decision only depends on posedge state.
  always_ff @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_made <= 1'b0;
      fetch_word <= '0;
    end else begin
      fetch_made <= poll_now;
      fetch_word <= poll_now ? dpi_msgReceive_beat() : 64'sd0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= POLL_READY;
      poll_cnt <= '0;
    end else begin
      state    <= state_nxt;
      poll_cnt <= poll_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    case (state)
      POLL_READY: begin
        if (fetch_made && !fetch_valid && (POLL_INTERVAL > 1)) begin
          state_nxt    = POLL_BACKOFF;
          poll_cnt_nxt = RELOAD;
        end
      end
      POLL_BACKOFF: begin
        poll_cnt_nxt = poll_cnt - 1'b1;
        if (poll_cnt == PCW'(1)) state_nxt = POLL_READY;
      end
      default: state_nxt = POLL_READY;
    endcase
  end

  vsim_beat_fifo #(
    .width (width),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .push      (push),
    .push_data (fetch_word[width-1:0]),
    .push_last (fetch_word[VSIM_BEAT_LAST_BIT]),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign beat__ENA = !empty;
  assign beat_v    = head_data;
  assign beat_last = head_last;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) inMessage <= 1'b0;
    else if (pop) inMessage <= !head_last;
  end

`ifdef VSIM_RECEIVE_STATS_EN
  logic [31:0] beats_received;
  logic [31:0] messages_received;
  logic [31:0] polls_empty;
  logic [31:0] full_stall_cycles;

  function automatic logic [31:0] sat_inc(input logic [31:0] cur, input logic en);
    return (en && (cur != 32'hFFFF_FFFF)) ? cur + 32'd1 : cur;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      beats_received    <= '0;
      messages_received <= '0;
      polls_empty       <= '0;
      full_stall_cycles <= '0;
    end else begin
      beats_received    <= sat_inc(beats_received, push);
      messages_received <= sat_inc(messages_received, pop && head_last);
      polls_empty       <= sat_inc(polls_empty, fetch_made && !fetch_valid);
      full_stall_cycles <= sat_inc(full_stall_cycles, (state == POLL_READY) && full);
    end
  end

  final begin
    $display("vsim_receive: beatsReceived=%0d messagesReceived=%0d pollsEmpty=%0d fullStallCycles=%0d",
             beats_received, messages_received, polls_empty, full_stall_cycles);
  end
`endif

endmodule
